dmem_lsu_ctrl: RTL and testbench
================================

// Module: dmem_lsu_ctrl
// PURPOSE
//  Load/store sequencer between the RV32I core and data_memory (registered read, word-wide write).
//  Turns one core request (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory cycles.
//  Sub-word stores use read-modify-write. Loads are byte/half extracted and sign/zero extended.
//  Sits between the execute stage and data_memory; data_memory has exactly one master, this block.
// PARAMETERS
//  AW  32  address width (core and memory side)
//  DW  32  data width; fixed at 32 (byte lanes hard-coded)
// PORTS
//  clk         in   1   single clock, all flops rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   core request present
//  req_ready   out  1   block idle, request accepted when valid&&ready
//  req_write   in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 of the load/store
//  req_addr    in   AW  byte address
//  req_wdata   in   DW  store data, LSB-justified
//  resp_valid  out  1   one-cycle completion pulse, for loads and stores
//  resp_rdata  out  DW  load result, extended; 0 for stores
//  resp_error  out  1   qualified by resp_valid; see CONFIGURATION
//  mem_address out  AW  {addr[AW-1:2],2'b00} to data_memory
//  mem_read    out  1   data_memory read strobe; rdata valid the cycle after
//  mem_write   out  1   data_memory full-word write strobe
//  mem_wdata   out  DW  full word to write
//  mem_rdata   in   DW  data_memory read data
// BEHAVIOUR
//  - Reset: state=IDLE. req_ready=1. resp_valid=0, resp_error=0, resp_rdata=0.
//    mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
//    mem_* strobes are decoded from state, so asserting rst mid-operation drops them at once.
//    Reset during WR means no write on the next edge. The in-flight request is lost; no resp_valid.
//  - Request (addr, funct3, wdata, write) is captured into registers on accept.
//    The req_* inputs are don't-care afterwards.
//  - req_ready=1 only in IDLE. A new request is accepted in the IDLE cycle after DONE.
//  - States: IDLE, RD, LDAT, MRG, WR, DONE.
//    - Load: IDLE -> RD (mem_read=1) -> LDAT (extract mem_rdata into resp_rdata) -> DONE.
//      resp_valid 3 cycles after accept.
//    - SW: IDLE -> WR (mem_write=1, mem_wdata=req_wdata) -> DONE.
//      resp_valid 2 cycles after accept.
//    - SB/SH: IDLE -> RD -> MRG (merge new lanes into mem_rdata) -> WR -> DONE.
//      resp_valid 4 cycles after accept.
//    - DONE: resp_valid=1 for exactly one cycle, then IDLE. No backpressure on resp.
//  - Lane select: byte lane = addr[1:0]; half lane = addr[1] (addr[0] ignored when the trap is off).
//  - Extract: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
//  - Merge: SB replaces lane addr[1:0] with wdata[7:0]. SH replaces half addr[1] with wdata[15:0].
//    Other lanes keep the old memory value.
//  - mem_address is held stable from RD through WR.
//  - resp_rdata holds its value until the next load completes.
// CONFIGURATION
//  Macro LSU_MISALIGN_TRAP_EN.
//  - Defined:
//    - Misaligned requests trap: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//    - Illegal funct3 traps: load 011/110/111; store with funct3 other than 000/001/010.
//    - A trapping request goes IDLE -> DONE with no memory strobe.
//      resp_error=1, resp_rdata=0, resp_valid 1 cycle after accept.
//  - Undefined:
//    - resp_error is tied to 0.
//    - Word ops ignore addr[1:0]; half ops ignore addr[0].
//    - Illegal load funct3 behaves as LW; store funct3[1]=1 behaves as SW.
// STRUCTURE
//  - Shared header rv32i_defs.vh: funct3 localparams F3_B/H/W/BU/HU; state encodings.
//  - Sub-module lsu_align (combinational):
//    - load_extract(word, addr[1:0], funct3) -> DW
//    - store_merge(old, wdata, addr[1:0], funct3) -> DW
//  - Top holds the FSM, request capture registers and output registers.
// TESTING
//  1. Pre-load mem[0x10..0x13]=0x80,0x7F,0xFF,0x01.
//     LB @0x10 -> resp_rdata=0xFFFFFF80, resp_valid 3 cycles after accept.
//  2. Same data. LBU @0x10 -> 0x00000080; LHU @0x12 -> 0x000001FF; LW @0x10 -> 0x01FF7F80.
//  3. SW 0xDEADBEEF @0x20 -> one mem_write cycle, resp 2 cycles after accept; LW @0x20 -> 0xDEADBEEF.
//  4. SB 0xAA @0x21, then SH 0x1234 @0x22 onto the case-3 word -> LW @0x20 = 0x1234AAEF.
//  5. Assert rst while in WR of an SB -> mem_write drops same cycle; word unchanged; no resp_valid.
//     Afterwards req_ready=1.
//  6. With LSU_MISALIGN_TRAP_EN, LW @0x22 -> no mem_read, resp_error=1, resp_rdata=0,
//     resp_valid 1 cycle after accept.
//     Without the macro, the same request -> LW of word 0x20, resp_error=0.

Source files
------------

// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared funct3 codes, FSM state encoding and the trap-decode helper
// for the load/store sequencer.
package dmem_lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LDAT,
        S_MRG,
        S_WR,
        S_DONE
    } state_t;

    // Illegal funct3 or an access not aligned to its own size.
    function automatic logic lsu_trap(input logic       write,
                                      input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (write)
            illegal = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        else
            illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Purely combinational; no latency, no flow control.
// Half ops look only at addr_lo[1]; word ops ignore addr_lo entirely.
module dmem_lsu_ctrl_align
    import dmem_lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_data = {24'b0, lane_b};
            F3_HU:   load_data = {16'b0, lane_h};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merge_data = old_word;
        if (funct3[1]) begin
            merge_data = wdata;
        end else if (funct3[0]) begin
            if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
            else            merge_data[15:0]  = wdata[15:0];
        end else begin
            case (addr_lo)
                2'd0:    merge_data[7:0]   = wdata[7:0];
                2'd1:    merge_data[15:8]  = wdata[7:0];
                2'd2:    merge_data[23:16] = wdata[7:0];
                default: merge_data[31:24] = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer to data_memory; sub-word stores by read-modify-write.
// Latency accept->resp_valid: load 3, SW 2, SB/SH 4, trap 1 (LSU_MISALIGN_TRAP_EN).
// req_ready only in IDLE; resp has no backpressure (single-cycle pulse).
module dmem_lsu_ctrl
    import dmem_lsu_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_error,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic          write_q, write_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          trap;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = lsu_trap(req_write, req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    dmem_lsu_ctrl_align u_align (
        .word       (mem_rdata),
        .old_word   (mem_rdata),
        .wdata      (wdata_q),
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                addr_d  = req_addr;
                f3_d    = req_funct3;
                write_d = req_write;
                wdata_d = req_wdata;
                err_d   = trap;
                if (trap)                           state_d = S_DONE;
                else if (req_write && req_funct3[1]) state_d = S_WR;
                else                                state_d = S_RD;
            end
            S_RD:    state_d = write_q ? S_MRG : S_LDAT;
            S_LDAT: begin
                rdata_d = load_data;
                state_d = S_DONE;
            end
            // wdata_q becomes the full merged word to write back
            S_MRG: begin
                wdata_d = merge_data;
                state_d = S_WR;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes come straight off the state register so reset kills them immediately.
    assign req_ready   = (state_q == S_IDLE);
    assign mem_read    = (state_q == S_RD);
    assign mem_write   = (state_q == S_WR);
    assign mem_address = {addr_q[AW-1:2], 2'b00};
    assign mem_wdata   = wdata_q;
    assign resp_valid  = (state_q == S_DONE);
    assign resp_error  = (state_q == S_DONE) && err_q;
    assign resp_rdata  = ((state_q == S_DONE) && (write_q || err_q)) ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a byte-addressed reference memory model.
module tb_dmem_lsu_ctrl;

    typedef struct {
        int          lat;
        int          due;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'b0;

    always #5 clk = ~clk;

    dmem_lsu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // data_memory stand-in: registered read, full-word write
    logic [31:0] dmem [0:63];
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= dmem[mem_address[7:2]];
        if (mem_write) dmem[mem_address[7:2]] <= mem_wdata;
    end

    logic [7:0]  refm [0:255];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rdata = 32'b0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Reference semantics on a byte memory: access size, alignment, extension.
    function automatic exp_t model(input logic w, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          size;
        logic        sgn;
        logic [31:0] base;
        logic [31:0] v;
        e.lat = 0; e.due = 0; e.rdata = 32'b0; e.err = 1'b0; e.nrd = 0; e.nwr = 0;
        e.waddr = {addr[31:2], 2'b00};
        if (w) size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        else   size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        sgn = (f3 == 3'd0) || (f3 == 3'd1);
`ifdef LSU_MISALIGN_TRAP_EN
        if (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) e.err = 1'b1;
        if ((addr % 32'(size)) != 0) e.err = 1'b1;
`endif
        base = addr - (addr % 32'(size));
        if (e.err) begin
            e.lat = 1;
        end else if (w) begin
            for (int i = 0; i < size; i++) refm[8'(base + 32'(i))] = wd[8*i +: 8];
            e.nwr = 1;
            e.nrd = (size < 4) ? 1 : 0;
            e.lat = (size == 4) ? 2 : 4;
        end else begin
            v = 32'b0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = refm[8'(base + 32'(i))];
            if (sgn && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
            e.nrd = 1;
            e.lat = 3;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if ((mem_read || mem_write) && q.size() != 0)
                chk("mem_address", mem_address, q[0].waddr);
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("resp_error", 32'(resp_error), 32'(q[0].err));
                chk("mem_read_cycles", 32'(rd_cnt), 32'(q[0].nrd));
                chk("mem_write_cycles", 32'(wr_cnt), 32'(q[0].nwr));
                last_rdata = resp_rdata;
                last_err   = resp_error;
                void'(q.pop_front());
            end else if (resp_valid) begin
                chk("resp_valid_spurious", 32'(resp_valid), 32'd0);
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   n;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        e = model(w, f3, addr, wd);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        e.due = cyc - 1 + e.lat;
        rd_cnt = 0; wr_cnt = 0;
        q.push_back(e);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout got=no_resp exp=resp_within_20_cycles");
            q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++)  dmem[i] = 32'b0;
        for (int i = 0; i < 256; i++) refm[i] = 8'b0;
        dmem[4] = 32'h01FF7F80;
        refm[16] = 8'h80; refm[17] = 8'h7F; refm[18] = 8'hFF; refm[19] = 8'h01;

        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 3'b000, 32'h10, 32'h0); chk("lit_lb_10",  last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h10, 32'h0); chk("lit_lbu_10", last_rdata, 32'h00000080);
        do_req(1'b0, 3'b101, 32'h12, 32'h0); chk("lit_lhu_12", last_rdata, 32'h000001FF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0); chk("lit_lw_10",  last_rdata, 32'h01FF7F80);
        do_req(1'b0, 3'b001, 32'h10, 32'h0); chk("lit_lh_10",  last_rdata, 32'h00007F80);
        do_req(1'b0, 3'b000, 32'h11, 32'h0); chk("lit_lb_11",  last_rdata, 32'h0000007F);
        do_req(1'b0, 3'b000, 32'h12, 32'h0); chk("lit_lb_12",  last_rdata, 32'hFFFFFFFF);
        do_req(1'b0, 3'b001, 32'h12, 32'h0); chk("lit_lh_12",  last_rdata, 32'h000001FF);

        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF); chk("lit_sw_rdata", last_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_lw_20_sw", last_rdata, 32'hDEADBEEF);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000AA);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_lw_20_sb", last_rdata, 32'hDEADAAEF);
        do_req(1'b1, 3'b001, 32'h22, 32'h00001234);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_lw_20_sh", last_rdata, 32'h1234AAEF);

        // reset lands in the WR cycle of an SB: the write must not happen
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wr_before_rst", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("wr_dropped_on_rst", 32'(mem_write), 32'd0);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_lw_20_after_rst", last_rdata, 32'h1234AAEF);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 3'b010, 32'h22, 32'h0); chk("lit_lw_22_err", 32'(last_err), 32'd1);
        chk("lit_lw_22_rdata", last_rdata, 32'h0);
        do_req(1'b0, 3'b001, 32'h11, 32'h0); chk("lit_lh_11_err", 32'(last_err), 32'd1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0); chk("lit_ld011_err", 32'(last_err), 32'd1);
        do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF); chk("lit_sh_21_err", 32'(last_err), 32'd1);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_lw_20_untouched", last_rdata, 32'h1234AAEF);
`else
        do_req(1'b0, 3'b010, 32'h22, 32'h0); chk("lit_lw_22_err", 32'(last_err), 32'd0);
        chk("lit_lw_22_rdata", last_rdata, 32'h1234AAEF);
        do_req(1'b0, 3'b001, 32'h11, 32'h0); chk("lit_lh_11", last_rdata, 32'h00007F80);
        do_req(1'b0, 3'b011, 32'h10, 32'h0); chk("lit_ld011_as_lw", last_rdata, 32'h01FF7F80);
        do_req(1'b1, 3'b011, 32'h20, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h20, 32'h0); chk("lit_st011_as_sw", last_rdata, 32'hCAFEF00D);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
